// File: rtl/jt6295_pkg.sv
// Shared constants for the jt6295 ADPCM fetch stage.
// NIB_HIGH marks the nibble emitted first from each ROM byte.
package jt6295_pkg;
   localparam int   ROM_AW   = 18;
   localparam int   NUM_CH   = 4;
   localparam int   CHW      = $clog2(NUM_CH);
   localparam logic NIB_HIGH = 1'b1;

   function automatic logic [3:0] nib_pick(input logic [7:0] b, input logic hi);
      return hi ? b[7:4] : b[3:0];
   endfunction
endpackage

// File: rtl/jt6295_fetch_arb.sv
// Round-robin grant over the voices waiting for a ROM byte.
// Search starts at the channel after the one served last.
module jt6295_fetch_arb
   import jt6295_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [CHW-1:0]    last,
   output logic [CHW-1:0]    grant,
   output logic              valid
);

   logic [CHW-1:0] idx;

   // walk from farthest to nearest so the nearest requester is written last
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = last + CHW'(i);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/jt6295_fetch.sv
// Per-voice playback state and ROM byte fetch for the ADPCM decoder.
// Emits one nibble per cen slot in channel order 0..3.
module jt6295_fetch
   import jt6295_pkg::*;
#(
   parameter int AW = ROM_AW,
   parameter int CH = NUM_CH
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cen,
   input  logic           start,
   input  logic [CHW-1:0] start_ch,
   input  logic [AW-1:0]  start_addr,
   input  logic [AW-1:0]  stop_addr,
   input  logic [3:0]     start_att,
   input  logic [CH-1:0]  stop_mask,
   output logic [CH-1:0]  busy,
   output logic [CH-1:0]  underrun,
   output logic           rom_cs,
   output logic [AW-1:0]  rom_addr,
   input  logic [7:0]     rom_data,
   input  logic           rom_ok,
   output logic [3:0]     dec_data,
   output logic           dec_en,
   output logic [3:0]     dec_att,
   output logic [CHW-1:0] dec_ch
);

   logic [AW-1:0]  addr     [CH];
   logic [AW-1:0]  end_addr [CH];
   logic [3:0]     att      [CH];
   logic [7:0]     byte_buf [CH];
   logic [CH-1:0]  buf_valid;
   logic [CH-1:0]  nib_sel;
   logic [CHW-1:0] slot;
   logic [CHW-1:0] req_ch;
   logic [CHW-1:0] last_ch;
   logic           req_stale;
   logic           start_ok;
   logic [CH-1:0]  cmd_hit;
   logic [CH-1:0]  arb_req;
   logic [CHW-1:0] arb_grant;
   logic           arb_valid;

   assign start_ok = start && (start_addr <= stop_addr);
   assign arb_req  = busy & ~buf_valid;

   // channels whose state is replaced this clk; their in-flight byte is stale
   always_comb begin
      cmd_hit = stop_mask;
      if (start_ok) cmd_hit[start_ch] = 1'b1;
   end

   jt6295_fetch_arb u_arb (
      .req   (arb_req),
      .last  (last_ch),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH; i++) begin
            addr[i]     <= '0;
            end_addr[i] <= '0;
            att[i]      <= '0;
            byte_buf[i] <= '0;
         end
         buf_valid <= '0;
         nib_sel   <= {CH{NIB_HIGH}};
         busy      <= '0;
         underrun  <= '0;
         slot      <= '0;
         dec_data  <= '0;
         dec_en    <= 1'b0;
         dec_att   <= '0;
         dec_ch    <= '0;
         rom_cs    <= 1'b0;
         rom_addr  <= '0;
         req_ch    <= '0;
         req_stale <= 1'b0;
         last_ch   <= CHW'(CH - 1);
      end else begin
         if (cen) begin
            slot     <= slot + CHW'(1);
            dec_ch   <= slot;
            dec_att  <= att[slot];
            dec_en   <= busy[slot];
            dec_data <= '0;
            if (busy[slot]) begin
               if (buf_valid[slot]) begin
                  dec_data      <= nib_pick(byte_buf[slot], nib_sel[slot] == NIB_HIGH);
                  nib_sel[slot] <= ~nib_sel[slot];
                  if (nib_sel[slot] != NIB_HIGH) begin
                     buf_valid[slot] <= 1'b0;
                     if (addr[slot] == end_addr[slot]) busy[slot] <= 1'b0;
                     else                              addr[slot] <= addr[slot] + AW'(1);
                  end
               end else begin
                  underrun[slot] <= 1'b1;
               end
            end
         end

         if (rom_cs) begin
            if (cmd_hit[req_ch]) req_stale <= 1'b1;
            if (rom_ok) begin
               rom_cs <= 1'b0;
               if (!req_stale) begin
                  byte_buf[req_ch]  <= rom_data;
                  buf_valid[req_ch] <= 1'b1;
               end
            end
         end else if (arb_valid) begin
            rom_cs    <= 1'b1;
            rom_addr  <= addr[arb_grant];
            req_ch    <= arb_grant;
            last_ch   <= arb_grant;
            req_stale <= cmd_hit[arb_grant];
         end

         // commands last so they override slot and capture updates
         for (int i = 0; i < CH; i++) begin
            if (stop_mask[i]) begin
               busy[i]      <= 1'b0;
               buf_valid[i] <= 1'b0;
            end
         end
         if (start_ok) begin
            addr[start_ch]      <= start_addr;
            end_addr[start_ch]  <= stop_addr;
            att[start_ch]       <= start_att;
            nib_sel[start_ch]   <= NIB_HIGH;
            buf_valid[start_ch] <= 1'b0;
            underrun[start_ch]  <= 1'b0;
            busy[start_ch]      <= 1'b1;
         end
      end
   end

endmodule
